// File: rtl/apb4_slave_regfile_if.sv
// APB4 bus bundle between the bridge (master) and a completer (slave).
// Clock and reset are not carried here; they stay plain ports on each block.
// Signals:
//   PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB  driven by the master
//   PREADY, PRDATA, PSLVERR                      driven by the slave
interface apb4_slave_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    PSEL;
    logic                    PENABLE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic                    PREADY;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb4_slave_regfile.sv
// APB4 completer with a MEM_DEPTH-word byte-strobed register file.
// Optional wait states are compiled in with the macro APB4_SLAVE_WAIT_EN;
// without it every transfer completes in the first ACCESS cycle.
// Ports:
//   PCLK     clock, rising edge
//   PRESETn  synchronous active-low reset (clears FSM, outputs and memory)
//   bus      APB4 slave modport: PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB in,
//            PREADY/PRDATA/PSLVERR out (all outputs registered)
// PADDR[ADDR_WIDTH-1] is the bridge's select bit and is ignored by decode.
module apb4_slave_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb4_slave_regfile_if.slave  bus
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int NLANES = DATA_WIDTH / 8;

`ifdef APB4_SLAVE_WAIT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_e;
    logic [3:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd2} state_e;
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    state_e                state_q, state_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    logic [IDX_W-1:0] idx;
    logic             err;
    logic             enter_ack;
    logic             sel_bit_unused;

    assign idx = bus.PADDR[IDX_W+1:2];
    assign err = (bus.PADDR[1:0] != 2'b00) ||
                 (bus.PADDR[ADDR_WIDTH-2:IDX_W+2] != '0);
    assign sel_bit_unused = bus.PADDR[ADDR_WIDTH-1];

    always_comb begin
        state_d   = state_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        mem_d     = mem_q;
        enter_ack = 1'b0;
`ifdef APB4_SLAVE_WAIT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
`ifdef APB4_SLAVE_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        enter_ack = 1'b1;
                    end
`else
                    enter_ack = 1'b1;
`endif
                end
            end
`ifdef APB4_SLAVE_WAIT_EN
            S_WAIT: begin
                // Master dropping PSEL mid-wait abandons the transfer silently.
                if (!bus.PSEL)          state_d   = S_IDLE;
                else if (cnt_q == 4'd0) enter_ack = 1'b1;
                else                    cnt_d     = cnt_q - 4'd1;
            end
`endif
            S_ACK: begin
                // Commit on the edge leaving ACK so a back-to-back read of the
                // same word, captured a cycle later, already sees the new data.
                state_d = S_IDLE;
                if (bus.PWRITE && !err) begin
                    for (int k = 0; k < NLANES; k++) begin
                        if (bus.PSTRB[k]) mem_d[idx][8*k +: 8] = bus.PWDATA[8*k +: 8];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_ack) begin
            state_d   = S_ACK;
            pready_d  = 1'b1;
            pslverr_d = err;
            prdata_d  = (!bus.PWRITE && !err) ? mem_q[idx] : '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
`ifdef APB4_SLAVE_WAIT_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            mem_q     <= mem_d;
`ifdef APB4_SLAVE_WAIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PRDATA  = prdata_q;
endmodule
